// File: rtl/adder_bist.sv
// adder_bist: built-in self-test engine that drives corner and LFSR vectors into a combinational
// WIDTH-bit adder and checks {cout,s} against a+b+cin. Define ADDER_BIST_FAIL_CAPTURE_EN to build first-failure capture.
module adder_bist #(
    parameter int          WIDTH       = 8,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_cout
);

    localparam int               TOTAL    = 4 + NUM_VECTORS;
    localparam int               IDX_W    = $clog2(TOTAL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL);
    localparam logic [31:0]      TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [15:0]      err_q, err_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WIDTH:0]   golden;
    logic             mismatch;
    logic [15:0]      err_inc;
    logic [31:0]      lfsr_next;
    logic [WIDTH-1:0] vec_a, vec_b;
    logic             vec_cin;
    logic             vec_rand;

    // Golden sum is one bit wider than the operands so the carry-out is checked too.
    assign golden    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign mismatch  = (golden != {cout, s});
    assign err_inc   = (mismatch && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        vec_a    = lfsr_q[WIDTH-1:0];
        vec_b    = lfsr_q[2*WIDTH-1:WIDTH];
        vec_cin  = lfsr_q[31];
        vec_rand = 1'b1;
        case (idx_q)
            IDX_W'(1): begin
                vec_a    = '1;
                vec_b    = '0;
                vec_cin  = 1'b1;
                vec_rand = 1'b0;
            end
            IDX_W'(2): begin
                vec_a    = '1;
                vec_b    = '1;
                vec_cin  = 1'b1;
                vec_rand = 1'b0;
            end
            IDX_W'(3): begin
                vec_a    = '1;
                vec_b    = '0;
                vec_cin  = 1'b0;
                vec_rand = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = 1'b0;
                    idx_d   = IDX_W'(1);
                end
            end
            S_RUN: begin
                err_d = err_inc;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc == 16'd0);
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = 1'b0;
                    idx_d   = '0;
                end else begin
                    a_d   = vec_a;
                    b_d   = vec_b;
                    cin_d = vec_cin;
                    idx_d = idx_q + IDX_W'(1);
                    if (vec_rand) begin
                        lfsr_d = lfsr_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic             fcin_q, fcin_d;
    logic [WIDTH-1:0] fs_q, fs_d;
    logic             fcout_q, fcout_d;

    // Only the first mismatch of a run is kept; a new start clears the record.
    always_comb begin
        seen_d  = seen_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fcin_d  = fcin_q;
        fs_d    = fs_q;
        fcout_d = fcout_q;
        if ((state_q == S_IDLE) && start) begin
            seen_d  = 1'b0;
            fa_d    = '0;
            fb_d    = '0;
            fcin_d  = 1'b0;
            fs_d    = '0;
            fcout_d = 1'b0;
        end else if ((state_q == S_RUN) && mismatch && !seen_q) begin
            seen_d  = 1'b1;
            fa_d    = a_q;
            fb_d    = b_q;
            fcin_d  = cin_q;
            fs_d    = s;
            fcout_d = cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q  <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fcin_q  <= 1'b0;
            fs_q    <= '0;
            fcout_q <= 1'b0;
        end else begin
            seen_q  <= seen_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fcin_q  <= fcin_d;
            fs_q    <= fs_d;
            fcout_q <= fcout_d;
        end
    end

    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_cin  = fcin_q;
    assign fail_s    = fs_q;
    assign fail_cout = fcout_q;
`else
    assign fail_a    = '0;
    assign fail_b    = '0;
    assign fail_cin  = 1'b0;
    assign fail_s    = '0;
    assign fail_cout = 1'b0;
`endif

endmodule
